pi_level_sequencer: RTL

PI_LEVEL_SEQUENCER -- requirements
Module: pi_level_sequencer

---
 rtl/pi_level_sequencer_if.sv | 24 ++
 rtl/pi_level_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/pi_level_sequencer_if.sv
// Handshake bundle for the priority-level sequencer: request/enable/ack
// inputs toward the sequencer, pending/in-progress/grant status back.
interface pi_level_sequencer_if;
  logic       pi_on;
  logic [7:0] req;
  logic [7:0] en;
  logic       ack;
  logic       dismiss;
  logic [7:0] pend;
  logic [7:0] ip;
  logic       any;
  logic       grant_v;
  logic [2:0] grant_lvl;

  modport master (
    output pi_on, req, en, ack, dismiss,
    input  pend, ip, any, grant_v, grant_lvl
  );

  modport slave (
    input  pi_on, req, en, ack, dismiss,
    output pend, ip, any, grant_v, grant_lvl
  );
endinterface

// File: rtl/pi_level_sequencer.sv
// Eight-level priority sequencer. Level 0 is the highest priority. Requests
// latch into pend, one eligible level at a time is offered as a grant, and
// acked levels are tracked in ip until dismissed. Lower-priority levels stay
// blocked while a higher-priority level is in progress.
module pi_level_sequencer (
  input logic                 clk,
  input logic                 rst,
  pi_level_sequencer_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [7:0] pend_q;
  logic [7:0] ip_q;
  logic       grant_v_q;
  logic [2:0] grant_lvl_q;

  logic [7:0] ip_low;
  logic [7:0] hmask;
  logic [7:0] elig;
  logic [2:0] elig_idx;
  logic [7:0] grant_bit;
  logic [7:0] pend_in;
  logic [7:0] pend_d;
  logic [7:0] ip_d;
  logic       take_ack;
  logic       withdraw;

  // Eligible set: pending, not in progress, and above the highest-priority in-progress level
  always_comb begin
    ip_low = ip_q & (~ip_q + 8'd1);
    // ip_low - 1 wraps to all-ones when nothing is in progress
    hmask  = ip_low - 8'd1;
    elig   = pend_q & ~ip_q & hmask;
  end

  // Lowest-index eligible level (scan from the bottom so the lowest index is written last)
  always_comb begin
    elig_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (elig[7 - i]) elig_idx = 3'(7 - i);
    end
  end

  // Next-state values for the pending and in-progress vectors
  always_comb begin
    grant_bit = 8'b1 << grant_lvl_q;
    take_ack  = (state == GRANT) && bus.ack;
    pend_in   = (pend_q | bus.req) & bus.en;
    pend_d    = take_ack ? (pend_in & ~grant_bit) : pend_in;
    withdraw  = (state == GRANT) && !bus.ack && !pend_in[grant_lvl_q];
    ip_d      = (bus.dismiss ? (ip_q & ~ip_low) : ip_q) | (take_ack ? grant_bit : '0);
  end

  // Registered state, pending/in-progress vectors and grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_q      <= '0;
      ip_q        <= '0;
      grant_v_q   <= 1'b0;
      grant_lvl_q <= '0;
    end else begin
      pend_q <= pend_d;
      ip_q   <= ip_d;
      case (state)
        IDLE: begin
          if (bus.pi_on && (elig != '0)) begin
            grant_lvl_q <= elig_idx;
            grant_v_q   <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (take_ack || withdraw) begin
            grant_v_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          grant_v_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.pend      = pend_q;
  assign bus.ip        = ip_q;
  assign bus.any       = |elig;
  assign bus.grant_v   = grant_v_q;
  assign bus.grant_lvl = grant_lvl_q;
endmodule
